sram_ctrl: RTL

Synchronous initiator for the board's external asynchronous SRAM (20-bit word address, 16-bit data, byte lanes). It accepts single-word read/write requests from the on-chip fabric through a ready/valid handshake. It sequences the SRAM pins (`ce_n`, `oe_n`, `we_n`, `lb_n`, `ub_n`, tri-state `dq`) with programmable cycle counts, and returns read data with a one-cycle valid pulse. It sits between the NES memory arbiter and the top-level SRAM pads.

---
 rtl/sram_ctrl_pkg.sv | 34 +++
 rtl/sram_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared types and defaults for the external asynchronous SRAM controller.
//   sram_state_e   : controller FSM states
//   SRAM_ADDR_W    : default SRAM word-address width
//   SRAM_DATA_W    : default SRAM data width (two byte lanes)
//   SRAM_RD_CYCLES : default oe_n-low cycles before dq is sampled
//   SRAM_WR_CYCLES : default we_n-low cycles
//   sram_cnt_w()   : width of the cycle down-counter for given cycle counts
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } sram_state_e;

  localparam int SRAM_ADDR_W    = 20;
  localparam int SRAM_DATA_W    = 16;
  localparam int SRAM_RD_CYCLES = 2;
  localparam int SRAM_WR_CYCLES = 2;

  // Counter must hold max(RD_CYCLES, WR_CYCLES) - 1; sized for max+1 so
  // a count of 1 still yields a 1-bit counter.
  function automatic int sram_cnt_w(input int rd, input int wr);
    int m;
    m = (rd > wr) ? rd : wr;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  localparam int SRAM_CNT_W = sram_cnt_w(SRAM_RD_CYCLES, SRAM_WR_CYCLES);

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl
// Synchronous initiator for an external asynchronous SRAM. Accepts single
// word read/write requests over ready/valid and sequences the SRAM pins with
// programmable read and write cycle counts. All pin outputs are registered.
//
// Ports
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_req / o_ready       : request handshake (accept on i_req & o_ready)
//   i_we                  : 1 = write, 0 = read
//   i_addr, i_wdata, i_be : word address, write data, byte enables
//   o_rdata, o_rvalid     : read data (held) and one-cycle update pulse
//   o_sram_*              : SRAM address and active-low control pins
//   io_sram_dq            : SRAM bidirectional data bus
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int RD_CYCLES = SRAM_RD_CYCLES,
  parameter int WR_CYCLES = SRAM_WR_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_be,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n,
  inout  wire  [DATA_W-1:0] io_sram_dq
);

  localparam int CNT_W = sram_cnt_w(RD_CYCLES, WR_CYCLES);

  sram_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic              lb_n_q;
  logic              ub_n_q;
  logic              dq_oe_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_req) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            ce_n_q  <= 1'b0;
            if (i_we) begin
              // Setup cycle: address, lanes and data settle before we_n falls.
              state_q <= ST_WR_SETUP;
              cnt_q   <= CNT_W'(WR_CYCLES - 1);
              lb_n_q  <= ~i_be[0];
              ub_n_q  <= ~i_be[1];
              dq_oe_q <= 1'b1;
            end else begin
              state_q <= ST_RD;
              cnt_q   <= CNT_W'(RD_CYCLES - 1);
              oe_n_q  <= 1'b0;
              lb_n_q  <= 1'b0;
              ub_n_q  <= 1'b0;
            end
          end
        end
        ST_RD: begin
          if (cnt_q == '0) begin
            rdata_q  <= io_sram_dq;
            rvalid_q <= 1'b1;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            state_q  <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WR_SETUP: begin
          we_n_q  <= 1'b0;
          state_q <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt_q == '0) begin
            // Data, address, ce_n and lanes stay put through the we_n rise.
            we_n_q  <= 1'b1;
            state_q <= ST_WR_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          ce_n_q  <= 1'b1;
          lb_n_q  <= 1'b1;
          ub_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_ready     = (state_q == ST_IDLE);
  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_sram_addr = addr_q;
  assign o_sram_ce_n = ce_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_we_n = we_n_q;
  assign o_sram_lb_n = lb_n_q;
  assign o_sram_ub_n = ub_n_q;
  assign io_sram_dq  = dq_oe_q ? wdata_q : 'z;

endmodule
